// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit signal bundle: ID/EX pipeline status in, stall/flush control out.
// The master side is the pipeline, and the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_md_start;
  logic        id_use_hilo;
  logic        ex_MemRead;
  logic        ex_RegWr;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        id_jump;

  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_stall;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_use_hilo,
           ex_MemRead, ex_RegWr, ex_rt, ex_branch_taken, id_jump,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, idex_stall,
           md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_use_hilo,
           ex_MemRead, ex_RegWr, ex_rt, ex_branch_taken, id_jump,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, idex_stall,
           md_busy, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div interlocks, and branch/jump flushes.
// It also tracks the multi-cycle MD unit and counts the bubbles inserted.
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LAT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_hazard_ctrl_if.slave       hz
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [4:0] MD_LOAD = 5'(MD_LAT - 1);

  state_e      state_q;
  logic [4:0]  md_cnt_q;
  logic        md_busy_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  logic lu_haz;
  logic mh_haz;
  logic md_issue;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  always_comb begin
    lu_haz = hz.ex_MemRead && (hz.ex_rt != 5'd0) &&
             ((hz.id_use_rs && (hz.id_rs == hz.ex_rt)) ||
              (hz.id_use_rt && (hz.id_rt == hz.ex_rt)));
    mh_haz   = md_busy_q && (hz.id_use_hilo || hz.id_md_start);
    md_issue = hz.id_md_start && !hz.ex_branch_taken && !lu_haz && !mh_haz;
  end

  // Only the highest-priority condition drives the controls: branch, then LU, then MH, then jump.
  always_comb begin
    hz.pc_stall   = 1'b0;
    hz.ifid_stall = 1'b0;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    hz.idex_stall = 1'b0;
    if (hz.ex_branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (lu_haz || mh_haz) begin
      hz.pc_stall   = 1'b1;
      hz.ifid_stall = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (hz.id_jump) begin
      hz.ifid_flush = 1'b1;
    end
  end

  // A branch during BUSY does not abort the MD op, so the count continues whatever the branch does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      md_cnt_q  <= 5'd0;
      md_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_issue) begin
            state_q   <= BUSY;
            md_cnt_q  <= MD_LOAD;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (md_cnt_q != 5'd0) begin
            md_cnt_q <= md_cnt_q - 5'd1;
          end else if (md_issue) begin
            md_cnt_q <= MD_LOAD;
          end else begin
            state_q   <= IDLE;
            md_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          md_cnt_q  <= 5'd0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.pc_stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 32'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign hz.md_busy   = md_busy_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl; a queue-based scoreboard checks it against a rule-level model.
module tb_pipeline_hazard_ctrl;
  localparam int MD_LAT = 8;

  typedef struct {
    bit       rst;
    bit [4:0] rs, rt, ex_rt;
    bit       use_rs, use_rt, start, hilo, mr, rw, br, jmp;
  } stim_t;

  typedef struct {
    bit        pc_stall, ifid_stall, ifid_flush, idex_flush, idex_stall, md_busy;
    bit [31:0] stall_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();
  pipeline_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (.clk(clk), .rst(rst), .hz(hz));

  exp_t      exp_q[$];
  int        n_chk  = 0;
  int        n_fail = 0;
  int        md_left = 0;     // number of MD-busy cycles still to come
  bit [31:0] m_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit   lu, mh, busy;
    @(negedge clk);
    rst                = s.rst;
    hz.id_rs           = s.rs;
    hz.id_rt           = s.rt;
    hz.id_use_rs       = s.use_rs;
    hz.id_use_rt       = s.use_rt;
    hz.id_md_start     = s.start;
    hz.id_use_hilo     = s.hilo;
    hz.ex_MemRead      = s.mr;
    hz.ex_RegWr        = s.rw;
    hz.ex_rt           = s.ex_rt;
    hz.ex_branch_taken = s.br;
    hz.id_jump         = s.jmp;
    if (s.rst) begin
      md_left = 0;
      m_cnt   = 0;
    end
    busy = (md_left > 0);
    lu   = s.mr && (s.ex_rt != 0) &&
           ((s.use_rs && s.rs == s.ex_rt) || (s.use_rt && s.rt == s.ex_rt));
    mh   = busy && (s.hilo || s.start);
    e = '{default: 0};
    e.md_busy   = busy;
    e.stall_cnt = m_cnt;
    if (s.br) begin
      e.ifid_flush = 1; e.idex_flush = 1;
    end else if (lu || mh) begin
      e.pc_stall = 1; e.ifid_stall = 1; e.idex_flush = 1;
    end else if (s.jmp) begin
      e.ifid_flush = 1;
    end
    exp_q.push_back(e);
    if (!s.rst) begin
      if (e.pc_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (busy) md_left--;
      else if (s.start && !s.br && !lu) md_left = MD_LAT;
    end
  endtask

  // The monitor samples a few ns after each drive edge, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_stall",   hz.pc_stall,   e.pc_stall);
        chk("ifid_stall", hz.ifid_stall, e.ifid_stall);
        chk("ifid_flush", hz.ifid_flush, e.ifid_flush);
        chk("idex_flush", hz.idex_flush, e.idex_flush);
        chk("idex_stall", hz.idex_stall, e.idex_stall);
        chk("md_busy",    hz.md_busy,    e.md_busy);
        chk("stall_cnt",  hz.stall_cnt,  e.stall_cnt);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle_s(); s.rst = 1;
    drive(s); drive(s);
    s = idle_s();
    drive(s);

    // Load-use on rs, then the same load into r0, then load-use masked by a taken branch.
    s = idle_s(); s.mr = 1; s.ex_rt = 5; s.rs = 5; s.use_rs = 1;
    drive(s);
    drive(idle_s());
    s.ex_rt = 0;
    drive(s);
    s.ex_rt = 5; s.br = 1;
    drive(s);
    s = idle_s(); s.jmp = 1;
    drive(s);

    // MD pulse, then mfhi held across the whole busy window.
    s = idle_s(); s.start = 1;
    drive(s);
    s = idle_s(); s.hilo = 1;
    repeat (MD_LAT + 3) drive(s);

    // A branch squashes the issue; then reset lands in the third busy cycle.
    s = idle_s(); s.start = 1; s.br = 1;
    drive(s);
    s.br = 0;
    drive(s);
    s = idle_s(); s.hilo = 1;
    drive(s); drive(s);
    s.rst = 1;
    drive(s);
    s.rst = 0;
    drive(s); drive(s);

    // Random traffic; the small register range and the occasional reset keep hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      s.rst    = ($urandom_range(0, 199) == 0);
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.ex_rt  = 5'($urandom_range(0, 3));
      s.use_rs = 1'($urandom_range(0, 1));
      s.use_rt = 1'($urandom_range(0, 1));
      s.start  = ($urandom_range(0, 7) == 0);
      s.hilo   = ($urandom_range(0, 3) == 0);
      s.mr     = 1'($urandom_range(0, 1));
      s.rw     = 1'($urandom_range(0, 1));
      s.br     = ($urandom_range(0, 5) == 0);
      s.jmp    = ($urandom_range(0, 5) == 0);
      drive(s);
    end

    @(negedge clk);
    #5;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
